pipe_stage_skid: RTL
====================

// Module: pipe_stage_skid
// PURPOSE
//  Generic, parametrised inter-stage pipeline register with a 2-entry skid buffer.
//  It replaces the fixed-field stage latches between fetch/decode/execute/mem/writeback.
//  The upstream stage drives a packed bus; the register holds it across stalls.
//  Adds valid/ready backpressure, flush with bubble insertion, and halt capture.
// PARAMETERS
//  DATA_W         160  width of packed stage payload (control + datapath fields)
//  RESET_VAL      '0   value loaded into payload registers on reset
//  ZERO_ON_FLUSH  1    1: flush also loads RESET_VAL into payloads; 0: payloads hold
// PORTS
//  CLK        in   1       clock, rising edge
//  nRST       in   1       reset, synchronous, active-low
//  in_valid   in   1       upstream payload valid
//  in_ready   out  1       block can accept (registered)
//  in_data    in   DATA_W  upstream payload
//  in_halt    in   1       payload carries the halt instruction
//  flush      in   1       discard all held entries (branch/jump mispredict)
//  out_valid  out  1       main entry valid
//  out_ready  in   1       downstream accepts
//  out_data   out  DATA_W  main entry payload (registered, no comb path from in_data)
//  out_halt   out  1       main entry is halt-tagged
//  halted     out  1       sticky: a halt-tagged entry has left via out handshake
//  occupancy  out  2       entries held: 0, 1 or 2
// BEHAVIOUR
//  - Reset (nRST=0 at edge): out_valid=0, out_halt=0, halted=0, occupancy=0,
//    in_ready=1, out_data=RESET_VAL, skid payload=RESET_VAL, halt_pend=0.
//  - acc = in_valid & in_ready; dep = out_valid & out_ready.
//  - States: EMPTY(occ 0), ONE(main valid), FULL(main+skid valid).
//    EMPTY: acc -> ONE (main<=in).
//    ONE:   acc&!dep -> FULL (skid<=in); acc&dep -> ONE (main<=in);
//           !acc&dep -> EMPTY; else hold.
//    FULL:  dep -> ONE (main<=skid); else hold. acc impossible (in_ready=0).
//  - in_ready = (next state != FULL) & !halt_pend, registered.
//  - Latency 1 cycle in->out from EMPTY; throughput 1/cycle sustained when out_ready=1.
//  - Order preserved; no entry dropped or duplicated except by flush.
//  - in_halt travels with its entry; out_halt reflects the main entry's tag.
//  - halt_pend sets on acc of a halt-tagged entry; while set, in_ready=0.
//    halted sets the cycle after dep with out_halt=1; only reset clears halted.
//  - Flush (sync, priority below reset, above all else): state->EMPTY,
//    occupancy=0, out_valid=0, out_halt=0, halt_pend=0, in_ready=1 next cycle;
//    same-cycle in_valid is dropped; dep in same cycle still counts downstream.
//    ZERO_ON_FLUSH=1: main/skid payloads <= RESET_VAL. halted unaffected.
//  - out_data stable while out_valid=1 & out_ready=0 (stall hold).
//  - Reset asserted mid-operation discards all entries, same as power-on reset.
// TESTING
//  1 Reset: nRST=0 for 2 cycles -> out_valid=0, in_ready=1, occupancy=0, out_data=RESET_VAL.
//  2 Streaming: out_ready=1, 4 beats 0xA..0xD back-to-back -> out 1 cycle later, in order,
//    occupancy=1 throughout.
//  3 Stall/skid: out_ready=0, send 0x11,0x22 -> occupancy=2, in_ready=0, out_data=0x11 held;
//    raise out_ready -> 0x11 then 0x22 emitted, in_ready=1 again.
//  4 Flush at FULL with in_valid=1 (0x33) -> next cycle occupancy=0, out_valid=0,
//    out_data=RESET_VAL; 0x33 never emitted.
//  5 Halt: send 0x44 with in_halt=1, then 0x55 -> 0x55 not accepted (in_ready=0);
//    on 0x44 dep, halted=1 next cycle and stays 1 through a later flush.
//  6 Random valid/ready 10k cycles vs. scoreboard FIFO -> exact in-order match, no loss.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a 2-entry skid buffer.
// Provides valid/ready backpressure, flush with bubble insertion and sticky halt capture.
module pipe_stage_skid #(
    parameter int unsigned       DATA_W        = 160,
    parameter logic [DATA_W-1:0] RESET_VAL     = '0,
    parameter bit                ZERO_ON_FLUSH = 1'b1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_halt,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_halt,
    output logic              halted,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              mainHalt_q, mainHalt_d;
    logic              skidHalt_q, skidHalt_d;
    logic              haltPend_q, haltPend_d;
    logic              halted_q, halted_d;
    logic              inReady_q, inReady_d;
    logic              acc, dep;

    assign acc = in_valid & inReady_q;
    assign dep = out_valid & out_ready;

    always_comb begin
        state_d    = state_q;
        main_d     = main_q;
        skid_d     = skid_q;
        mainHalt_d = mainHalt_q;
        skidHalt_d = skidHalt_q;
        haltPend_d = haltPend_q;
        halted_d   = halted_q;

        case (state_q)
            EMPTY: begin
                if (acc) begin
                    state_d    = ONE;
                    main_d     = in_data;
                    mainHalt_d = in_halt;
                end
            end
            ONE: begin
                if (acc && !dep) begin
                    state_d    = FULL;
                    skid_d     = in_data;
                    skidHalt_d = in_halt;
                end else if (acc && dep) begin
                    main_d     = in_data;
                    mainHalt_d = in_halt;
                end else if (dep) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (dep) begin
                    state_d    = ONE;
                    main_d     = skid_q;
                    mainHalt_d = skidHalt_q;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (acc && in_halt) begin
            haltPend_d = 1'b1;
        end
        if (dep && mainHalt_q) begin
            halted_d = 1'b1;
        end

        // A departure in the flush cycle has already been seen downstream, so halted may still set.
        if (flush) begin
            state_d    = EMPTY;
            haltPend_d = 1'b0;
            mainHalt_d = 1'b0;
            skidHalt_d = 1'b0;
            if (ZERO_ON_FLUSH) begin
                main_d = RESET_VAL;
                skid_d = RESET_VAL;
            end
        end

        inReady_d = (state_d != FULL) && !haltPend_d;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q    <= EMPTY;
            main_q     <= RESET_VAL;
            skid_q     <= RESET_VAL;
            mainHalt_q <= 1'b0;
            skidHalt_q <= 1'b0;
            haltPend_q <= 1'b0;
            halted_q   <= 1'b0;
            inReady_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            mainHalt_q <= mainHalt_d;
            skidHalt_q <= skidHalt_d;
            haltPend_q <= haltPend_d;
            halted_q   <= halted_d;
            inReady_q  <= inReady_d;
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign out_halt  = mainHalt_q & out_valid;
    assign halted    = halted_q;
    assign occupancy = (state_q == FULL) ? 2'd2 : ((state_q == ONE) ? 2'd1 : 2'd0);

endmodule
